// File: rtl/seq_code_ctrl.sv
// Step-indexed code-entry controller for the PBP lock: serial bit compare,
// counted unlock hold, and a timed lockout after repeated failed attempts.
module seq_code_ctrl #(
  parameter int unsigned          CODE_LEN    = 8,
  parameter logic [CODE_LEN-1:0]  CODE        = 8'b1011_0010,
  parameter int unsigned          HOLD_CYCLES = 100,
  parameter int unsigned          MAX_FAILS   = 3,
  parameter int unsigned          LOCK_CYCLES = 1000,
  localparam int unsigned         STEP_W      = $clog2(CODE_LEN),
  localparam int unsigned         FCNT_W      = $clog2(MAX_FAILS + 1)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ENTRY_VALID,
  input  logic              ENTRY_BIT,
  input  logic              CLEAR,
  output logic              UNLOCK,
  output logic              LOCKOUT,
  output logic              ERR,
  output logic [STEP_W-1:0] STEP,
  output logic [FCNT_W-1:0] FAIL_CNT
);

  localparam int unsigned STEP_SPAN = 1 << STEP_W;
  localparam int unsigned TMR_MAX   = (HOLD_CYCLES > LOCK_CYCLES) ? HOLD_CYCLES : LOCK_CYCLES;
  localparam int unsigned TMR_W     = ($clog2(TMR_MAX) < 1) ? 1 : $clog2(TMR_MAX);

  // Code stored bit-reversed so the current STEP indexes it directly; unused tail is zero.
  function automatic logic [STEP_SPAN-1:0] reverse_code(input logic [CODE_LEN-1:0] c);
    logic [STEP_SPAN-1:0] r;
    r = {STEP_SPAN{1'b0}};
    for (int i = 0; i < CODE_LEN; i++) begin
      r[i] = c[CODE_LEN-1-i];
    end
    return r;
  endfunction

  localparam logic [STEP_SPAN-1:0] CODE_REV  = reverse_code(CODE);
  localparam logic [STEP_W-1:0]    STEP_LAST = STEP_W'(CODE_LEN - 1);
  localparam logic [FCNT_W-1:0]    FCNT_LAST = FCNT_W'(MAX_FAILS - 1);
  localparam logic [FCNT_W-1:0]    FCNT_MAX  = FCNT_W'(MAX_FAILS);
  localparam logic [TMR_W-1:0]     HOLD_LOAD = TMR_W'(HOLD_CYCLES - 1);
  localparam logic [TMR_W-1:0]     LOCK_LOAD = TMR_W'(LOCK_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_ENTER   = 2'd0,
    ST_SUCCESS = 2'd1,
    ST_LOCKED  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
  logic [TMR_W-1:0]    tmr_q, tmr_d;
  logic                unlock_q, unlock_d;
  logic                lockout_q, lockout_d;
  logic                err_q, err_d;

  // Next-state, progress, fail-count and timer computation.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    fcnt_d  = fcnt_q;
    tmr_d   = tmr_q;
    err_d   = 1'b0;
    case (state_q)
      ST_ENTER: begin
        if (CLEAR) begin
          step_d = {STEP_W{1'b0}};
        end else if (ENTRY_VALID) begin
          if (ENTRY_BIT == CODE_REV[step_q]) begin
            if (step_q == STEP_LAST) begin
              state_d = ST_SUCCESS;
              step_d  = {STEP_W{1'b0}};
              fcnt_d  = {FCNT_W{1'b0}};
              tmr_d   = HOLD_LOAD;
            end else begin
              step_d = step_q + STEP_W'(1'b1);
            end
          end else begin
            // A wrong bit restarts the attempt; it is not reused as a first bit.
            step_d = {STEP_W{1'b0}};
            err_d  = 1'b1;
            if (fcnt_q == FCNT_LAST) begin
              state_d = ST_LOCKED;
              fcnt_d  = FCNT_MAX;
              tmr_d   = LOCK_LOAD;
            end else begin
              fcnt_d = fcnt_q + FCNT_W'(1'b1);
            end
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_SUCCESS: begin
        step_d = {STEP_W{1'b0}};
        if (tmr_q == {TMR_W{1'b0}}) begin
          state_d = ST_ENTER;
        end else begin
          tmr_d = tmr_q - TMR_W'(1'b1);
        end
      end
      ST_LOCKED: begin
        step_d = {STEP_W{1'b0}};
        if (tmr_q == {TMR_W{1'b0}}) begin
          state_d = ST_ENTER;
          fcnt_d  = {FCNT_W{1'b0}};
        end else begin
          tmr_d = tmr_q - TMR_W'(1'b1);
        end
      end
      default: begin
        state_d = ST_ENTER;
        step_d  = {STEP_W{1'b0}};
        fcnt_d  = {FCNT_W{1'b0}};
        tmr_d   = {TMR_W{1'b0}};
      end
    endcase
    unlock_d  = (state_d == ST_SUCCESS);
    lockout_d = (state_d == ST_LOCKED);
  end

  // State and registered outputs, synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_ENTER;
      step_q    <= {STEP_W{1'b0}};
      fcnt_q    <= {FCNT_W{1'b0}};
      tmr_q     <= {TMR_W{1'b0}};
      unlock_q  <= 1'b0;
      lockout_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      fcnt_q    <= fcnt_d;
      tmr_q     <= tmr_d;
      unlock_q  <= unlock_d;
      lockout_q <= lockout_d;
      err_q     <= err_d;
    end
  end

  assign UNLOCK   = unlock_q;
  assign LOCKOUT  = lockout_q;
  assign ERR      = err_q;
  assign STEP     = step_q;
  assign FAIL_CNT = fcnt_q;

endmodule
